// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the instruction-fetch front end:
//   fetch_state_e    - fetch controller FSM states
//   PC_RESET_VECTOR  - default first fetch address after reset
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        WAIT       = 2'd2,
        REDIR_PEND = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// ---------------------------------------------------------------------------
// pc_adder
// Sequential-fetch incrementer: pc_plus4 = pc + 4, wrapping modulo 2^WIDTH.
// Ports:
//   pc        in   WIDTH  current fetch address
//   pc_plus4  out  WIDTH  next sequential fetch address
// ---------------------------------------------------------------------------
module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + WIDTH'(4);

endmodule : pc_adder

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Program-counter and fetch-sequencing controller. Advances the PC when the
// instruction memory completes a request, holds on hazard stalls or memory
// wait, and applies branch/jump redirects. A redirect arriving while a memory
// request is outstanding is parked in pend_pc until that request completes;
// the instruction returned on that cycle is marked stale via discard.
// Ports:
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous reset, active low
//   stall         in   1      hazard hold of sequential advance
//   PCsrc         in   1      redirect request from EX
//   redir_target  in   WIDTH  redirect address (low two bits ignored)
//   imem_rdy      in   1      instruction memory completes request this cycle
//   pc            out  WIDTH  current fetch address
//   pc_plus4      out  WIDTH  pc + 4
//   fetch_valid   out  1      fetch request active at pc
//   flush         out  1      kill IF/ID and ID/EX this cycle
//   discard       out  1      returned instruction is stale
//   redir_count   out  16     saturating count of accepted redirects
// ---------------------------------------------------------------------------
module fetch_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             imem_rdy,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic             discard,
    output logic [15:0]      redir_count
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [15:0]      redir_count_q, redir_count_d;

    logic [WIDTH-1:0] target_aligned;
    logic [1:0]       unused_target_lsbs;

    // Instructions are word aligned; the low target bits carry no meaning.
    assign target_aligned     = {redir_target[WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = redir_target[1:0];

    pc_adder #(.WIDTH(WIDTH)) u_pc_adder (
        .pc       (pc_q),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        fetch_valid = (state_q != BOOT);
        flush       = 1'b0;
        discard     = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (PCsrc) begin
                    // No request outstanding that must be waited out: redirect now.
                    flush = 1'b1;
                    pc_d  = target_aligned;
                end else if (imem_rdy) begin
                    if (!stall) pc_d = pc_plus4;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (PCsrc) begin
                    flush     = 1'b1;
                    pend_pc_d = target_aligned;
                    if (imem_rdy) begin
                        pc_d    = target_aligned;
                        state_d = RUN;
                    end else begin
                        state_d = REDIR_PEND;
                    end
                end else if (imem_rdy) begin
                    state_d = RUN;
                    if (!stall) pc_d = pc_plus4;
                end
            end

            REDIR_PEND: begin
                if (PCsrc) begin
                    flush     = 1'b1;
                    pend_pc_d = target_aligned;
                end
                if (imem_rdy) begin
                    // The completing request belongs to the old path.
                    discard = 1'b1;
                    pc_d    = PCsrc ? target_aligned : pend_pc_q;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        redir_count_d = redir_count_q;
        if (flush && (redir_count_q != 16'hFFFF)) begin
            redir_count_d = redir_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_pc_q     <= RESET_VECTOR;
            redir_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            redir_count_q <= redir_count_d;
        end
    end

    assign pc          = pc_q;
    assign redir_count = redir_count_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Scoreboard bench for fetch_ctrl. The stimulus process drives one cycle of
// inputs, asks a behavioural model for that cycle's outputs and queues them;
// the monitor process pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          PCsrc = 1'b0;
    logic [W-1:0]  redir_target = '0;
    logic          imem_rdy = 1'b0;
    logic [W-1:0]  pc, pc_plus4;
    logic          fetch_valid, flush, discard;
    logic [15:0]   redir_count;

    fetch_ctrl #(.WIDTH(W), .RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .PCsrc        (PCsrc),
        .redir_target (redir_target),
        .imem_rdy     (imem_rdy),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .discard      (discard),
        .redir_count  (redir_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fv;
        logic        fl;
        logic        dc;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model, phrased as "fetch address, outstanding memory request,
    // optional parked redirect" rather than as an FSM.
    logic [31:0] m_pc;
    bit          m_booting;     // first cycle after reset release: idle
    bit          m_mem_busy;    // a request has seen at least one not-ready cycle
    logic [31:0] m_parked[$];   // at most one parked redirect target
    int          m_redirects;

    task automatic model_reset();
        m_pc        = RV;
        m_booting   = 1;
        m_mem_busy  = 0;
        m_parked    = {};
        m_redirects = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle, compute the expected outputs, advance the model.
    task automatic step(input bit r, input bit st, input bit ps,
                        input logic [31:0] tgt, input bit rdy);
        exp_t        e;
        logic [31:0] t;
        @(posedge clk);
        #1;
        rst = r; stall = st; PCsrc = ps; redir_target = tgt; imem_rdy = rdy;
        t = tgt & 32'hFFFF_FFFC;
        if (!r) begin
            model_reset();
            e.pc = RV; e.pc4 = RV + 32'd4; e.fv = 0; e.fl = 0; e.dc = 0; e.cnt = 16'd0;
            exp_q.push_back(e);
            return;
        end
        e.pc  = m_pc;
        e.pc4 = m_pc + 32'd4;
        e.cnt = (m_redirects > 65535) ? 16'hFFFF : 16'(m_redirects);
        if (m_booting) begin
            e.fv = 0; e.fl = 0; e.dc = 0;
            exp_q.push_back(e);
            m_booting = 0;
            return;
        end
        e.fv = 1;
        e.fl = ps;                                // every accepted redirect flushes
        e.dc = (m_parked.size() != 0) && rdy;     // stale return of the old path
        exp_q.push_back(e);
        if (ps) m_redirects++;
        if (m_parked.size() != 0) begin
            if (ps) m_parked[0] = t;
            if (rdy) begin
                m_pc = m_parked.pop_front();
                m_mem_busy = 0;
            end
        end else if (ps) begin
            if (m_mem_busy && !rdy) begin
                m_parked.push_back(t);
            end else begin
                m_pc = t;
                m_mem_busy = 0;
            end
        end else if (rdy) begin
            if (!st) m_pc = m_pc + 32'd4;
            m_mem_busy = 0;
        end else begin
            m_mem_busy = 1;
        end
    endtask

    // Monitor: one output set per cycle, compared at the falling edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc",          pc,                  e.pc);
                check("pc_plus4",    pc_plus4,            e.pc4);
                check("fetch_valid", 32'(fetch_valid),    32'(e.fv));
                check("flush",       32'(flush),          32'(e.fl));
                check("discard",     32'(discard),        32'(e.dc));
                check("redir_count", 32'(redir_count),    32'(e.cnt));
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout pending %0d expected %0d", exp_q.size(), 0);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Reset, release, sequential fetch from the reset vector.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
        // Redirect at 0x10 to an unaligned target.
        step(1, 0, 1, 32'h10, 1);
        step(1, 0, 1, 32'h103, 1);
        step(1, 0, 0, 0, 1);
        // Memory wait at 0x20.
        step(1, 0, 1, 32'h20, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Redirect parked behind an outstanding request at 0x40.
        step(1, 0, 1, 32'h40, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h200, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Parked redirect replaced by a newer one, completing together.
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h500, 0);
        step(1, 0, 1, 32'h604, 0);
        step(1, 0, 1, 32'h708, 1);
        step(1, 0, 0, 0, 1);
        // Stall versus redirect at 0x80.
        step(1, 0, 1, 32'h80, 1);
        step(1, 1, 1, 32'h300, 1);
        step(1, 0, 1, 32'h80, 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Wrap at the top of the address space.
        step(1, 0, 1, 32'hFFFF_FFFC, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Reset while a redirect is parked.
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h900, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        #1;
        check("pc_async_reset", pc, RV);
        check("discard_async_reset", 32'(discard), 32'd0);
        check("flush_async_reset", 32'(flush), 32'd0);
        step(0, 0, 1, 32'h900, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom(),
                 ($urandom_range(0, 2) != 0));
        end
        // Drive redir_count into saturation.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 65545; i++) begin
            step(1, 0, 1, $urandom(), $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_ctrl
